// File: rtl/data_storage.sv
// -----------------------------------------------------------------------------
// data_storage
//   Data memory for the MIPS datapath, sitting between the MEM stage and a
//   word-addressed backing array. One request port with a valid/ready
//   handshake, byte/half/word access, sign- or zero-extended loads, an
//   in-order response pipeline of READ_LATENCY stages and an alignment/range
//   fault. After reset the block sweeps the array to zero (INIT) before it
//   starts accepting requests (RUN).
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_req_valid  request present
//   o_req_ready  block can accept (low only while clearing)
//   i_req_write  1 = store, 0 = load
//   i_req_size   00 byte, 01 half, 10 word, 11 illegal (faults)
//   i_req_signed loads only: 1 = sign-extend, 0 = zero-extend
//   i_req_addr   byte address
//   i_req_wdata  store data, right-justified
//   o_rsp_valid  one-cycle pulse per accepted request, in order
//   o_rsp_rdata  extended load data; 0 for stores, faults and idle cycles
//   o_rsp_fault  misaligned, out of range or illegal size
//   o_init_done  high once the clear sweep has finished
// -----------------------------------------------------------------------------
module data_storage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h1000_0000,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_fault,
  output logic                  o_init_done
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH_WORDS * BYTES);
  localparam logic [IDX_W-1:0]      LAST_PTR  = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_clr_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_ready;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [LANE_BITS-1:0]  w_lane;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_range_err;
  logic                  w_align_err;
  logic                  w_fault;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_shift;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [BYTES-1:0]      w_wr_mask;
  logic [DATA_WIDTH-1:0] w_wr_data;

  logic                  r_pv [READ_LATENCY];
  logic [DATA_WIDTH-1:0] r_pd [READ_LATENCY];
  logic                  r_pf [READ_LATENCY];

  // ---------------------------------------------------------------------------
  // Address decode. The subtraction wraps, so addresses below BASE_ADDR land
  // far above MEM_BYTES and are caught by the same range compare.
  // ---------------------------------------------------------------------------
  assign w_off       = i_req_addr - BASE_ADDR;
  assign w_lane      = w_off[LANE_BITS-1:0];
  assign w_idx       = w_off[LANE_BITS +: IDX_W];
  assign w_range_err = (w_off >= MEM_BYTES);
  assign w_fault     = w_range_err || w_align_err;

  // Reset wins over a same-cycle request so nothing is written or queued.
  assign w_accept    = i_req_valid && w_ready && !i_rst;

  assign o_req_ready = w_ready;
  assign o_init_done = w_ready;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic: INIT ends on the cycle that clears the last word
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_clr_ptr == LAST_PTR) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_INIT;
        end
      end
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  // FSM output logic: ready only in RUN
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_INIT: w_ready = 1'b0;
      ST_RUN:  w_ready = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  // Clear-sweep pointer, one word per INIT cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clr_ptr <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_clr_ptr == LAST_PTR) begin
        r_clr_ptr <= '0;
      end else begin
        r_clr_ptr <= r_clr_ptr + IDX_W'(1);
      end
    end else begin
      r_clr_ptr <= r_clr_ptr;
    end
  end

  // Alignment / illegal-size check
  always_comb begin
    w_align_err = 1'b0;
    case (i_req_size)
      2'b00:   w_align_err = 1'b0;
      2'b01:   w_align_err = w_off[0];
      2'b10:   w_align_err = |w_lane;
      default: w_align_err = 1'b1;
    endcase
  end

  // Store byte-enables, little-endian lanes
  always_comb begin
    w_wr_mask = '0;
    case (i_req_size)
      2'b00:   w_wr_mask = BYTES'(1'b1) << w_lane;
      2'b01:   w_wr_mask = BYTES'(2'b11) << w_lane;
      2'b10:   w_wr_mask = '1;
      default: w_wr_mask = '0;
    endcase
  end

  assign w_wr_data  = i_req_wdata << {w_lane, 3'b000};

  // Combinational read at accept: a store on the previous edge is already
  // in the array, which gives store-then-load forwarding for free.
  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

  // Load lane selection and extension; stores and faults return zero
  always_comb begin
    w_load_data = '0;
    if (i_req_write || w_fault) begin
      w_load_data = '0;
    end else begin
      case (i_req_size)
        2'b00: begin
          if (i_req_signed) begin
            w_load_data = {{(DATA_WIDTH-8){w_rd_shift[7]}}, w_rd_shift[7:0]};
          end else begin
            w_load_data = {{(DATA_WIDTH-8){1'b0}}, w_rd_shift[7:0]};
          end
        end
        2'b01: begin
          if (i_req_signed) begin
            w_load_data = {{(DATA_WIDTH-16){w_rd_shift[15]}}, w_rd_shift[15:0]};
          end else begin
            w_load_data = {{(DATA_WIDTH-16){1'b0}}, w_rd_shift[15:0]};
          end
        end
        2'b10:   w_load_data = w_rd_shift;
        default: w_load_data = '0;
      endcase
    end
  end

  // Memory array: zero sweep during INIT, masked store on accept in RUN.
  // No reset here; the sweep is what clears it.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_accept && i_req_write && !w_fault) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_wr_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures at the accept edge, the last stage
  // drives the outputs. Data/fault are zero in every non-valid slot so the
  // outputs are already zero when idle. Reset drops everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pv[k] <= 1'b0;
        r_pd[k] <= '0;
        r_pf[k] <= 1'b0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pd[0] <= w_accept ? w_load_data : '0;
      r_pf[0] <= w_accept && w_fault;
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pd[k] <= r_pd[k-1];
        r_pf[k] <= r_pf[k-1];
      end
    end
  end

  assign o_rsp_valid = r_pv[READ_LATENCY-1];
  assign o_rsp_rdata = r_pd[READ_LATENCY-1];
  assign o_rsp_fault = r_pf[READ_LATENCY-1];

endmodule

// File: tb/tb_data_storage.sv
// -----------------------------------------------------------------------------
// tb_data_storage
//   Four copies of data_storage (READ_LATENCY 1..4, DEPTH_WORDS 16) share one
//   request stream. Each issued request pushes its hand-computed response into
//   one queue per copy; a monitor pops and compares whenever a copy pulses
//   rsp_valid, and also checks the response cycle against the accept edge.
// -----------------------------------------------------------------------------
module tb_data_storage;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          acc_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy   [4];
  logic        rsp_v [4];
  logic        rsp_f [4];
  logic        idone [4];
  logic [31:0] rsp_d [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_storage #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (DEPTH),
      .READ_LATENCY(g + 1)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .o_req_ready (rdy[g]),
      .i_req_write (req_write),
      .i_req_size  (req_size),
      .i_req_signed(req_signed),
      .i_req_addr  (req_addr),
      .i_req_wdata (req_wdata),
      .o_rsp_valid (rsp_v[g]),
      .o_rsp_rdata (rsp_d[g]),
      .o_rsp_fault (rsp_f[g]),
      .o_init_done (idone[g])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s [lat%0d] t=%0t: got %h want %h", nm, k + 1, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (rsp_v[k] === 1'b1) begin
      case (k)
        0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
        2: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
        3: if (q3.size() != 0) begin e = q3.pop_front(); have = 1'b1; end
        default: have = 1'b0;
      endcase
      if (!have) begin
        total++;
        bad++;
        $display("FAIL stale_rsp [lat%0d] t=%0t: unexpected rsp_valid rdata=%h", k + 1, $time, rsp_d[k]);
      end else begin
        chk("rsp_rdata", k, rsp_d[k], e.data);
        chk("rsp_fault", k, 32'(rsp_f[k]), 32'(e.fault));
        chk("rsp_cycle", k, 32'(cyc), 32'(e.acc_edge + k));
      end
    end else begin
      chk("idle_valid", k, 32'(rsp_v[k]), 32'd0);
      chk("idle_rdata", k, rsp_d[k], 32'd0);
      chk("idle_fault", k, 32'(rsp_f[k]), 32'd0);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) check_inst(k);
    end
  endtask

  // Called at a negedge; request is accepted at the following posedge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] ed, input logic ef);
    exp_t e;
    for (int k = 0; k < 4; k++) chk("req_ready", k, 32'(rdy[k]), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    e.data     = ed;
    e.fault    = ef;
    e.acc_edge = cyc + 1;
    q0.push_back(e);
    q1.push_back(e);
    q2.push_back(e);
    q3.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One-cycle reset; everything still queued is due at or after the reset
  // edge and must never appear.
  task automatic do_reset();
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the negedge right after the last reset edge.
  task automatic wait_init();
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 4; k++) begin
        chk("ready_in_init", k, 32'(rdy[k]), 32'd0);
        chk("done_in_init", k, 32'(idone[k]), 32'd0);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      chk("ready_after_init", k, 32'(rdy[k]), 32'd1);
      chk("done_after_init", k, 32'(idone[k]), 32'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (3) @(negedge clk);

    // Reset state
    for (int k = 0; k < 4; k++) begin
      chk("rst_ready", k, 32'(rdy[k]), 32'd0);
      chk("rst_valid", k, 32'(rsp_v[k]), 32'd0);
      chk("rst_rdata", k, rsp_d[k], 32'd0);
      chk("rst_fault", k, 32'(rsp_f[k]), 32'd0);
      chk("rst_done", k, 32'(idone[k]), 32'd0);
    end
    fork
      monitor();
    join_none
    rst = 1'b0;
    wait_init();

    // T1: every word reads 0 after the sweep
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 2'b10, 1'b0, BASE + 32'(4 * i), 32'd0, 32'd0, 1'b0);
    idle(2);

    // T2: word store then lane reads, little-endian
    issue(1'b1, 2'b10, 1'b0, BASE,         32'h8070_F0A5, 32'h0000_0000, 1'b0);
    issue(1'b0, 2'b00, 1'b1, BASE + 32'd1, 32'd0,         32'hFFFF_FFF0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, BASE + 32'd1, 32'd0,         32'h0000_00F0, 1'b0);
    issue(1'b0, 2'b00, 1'b1, BASE + 32'd3, 32'd0,         32'hFFFF_FF80, 1'b0);
    issue(1'b0, 2'b00, 1'b1, BASE + 32'd2, 32'd0,         32'h0000_0070, 1'b0);
    issue(1'b0, 2'b01, 1'b1, BASE + 32'd2, 32'd0,         32'hFFFF_8070, 1'b0);
    issue(1'b0, 2'b01, 1'b0, BASE + 32'd2, 32'd0,         32'h0000_8070, 1'b0);
    issue(1'b0, 2'b01, 1'b1, BASE,         32'd0,         32'hFFFF_F0A5, 1'b0);
    issue(1'b0, 2'b10, 1'b1, BASE,         32'd0,         32'h8070_F0A5, 1'b0);
    idle(1);

    // T3: half and byte stores merge into an existing word
    issue(1'b1, 2'b10, 1'b0, BASE + 32'd4, 32'h1122_3344, 32'h0000_0000, 1'b0);
    issue(1'b1, 2'b01, 1'b0, BASE + 32'd6, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd4, 32'd0,         32'hBEEF_3344, 1'b0);
    issue(1'b1, 2'b00, 1'b0, BASE + 32'd5, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0);
    issue(1'b0, 2'b10, 1'b1, BASE + 32'd4, 32'd0,         32'hBEEF_5A44, 1'b0);
    idle(1);

    // T4: faults, range edges, memory untouched by faulting stores
    issue(1'b0, 2'b01, 1'b1, BASE + 32'd1,  32'd0,         32'd0,         1'b1);
    issue(1'b1, 2'b10, 1'b0, BASE + 32'd64, 32'hCAFE_BABE, 32'd0,         1'b1);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd60, 32'd0,         32'd0,         1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE,          32'd0,         32'h8070_F0A5, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE - 32'd4,  32'd0,         32'd0,         1'b1);
    issue(1'b0, 2'b11, 1'b0, BASE,          32'd0,         32'd0,         1'b1);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd2,  32'd0,         32'd0,         1'b1);
    issue(1'b1, 2'b10, 1'b0, BASE + 32'd2,  32'h1234_5678, 32'd0,         1'b1);
    issue(1'b1, 2'b01, 1'b0, BASE + 32'd3,  32'h0000_FFFF, 32'd0,         1'b1);
    issue(1'b0, 2'b00, 1'b0, BASE + 32'd63, 32'd0,         32'd0,         1'b0);
    issue(1'b0, 2'b00, 1'b0, BASE + 32'd64, 32'd0,         32'd0,         1'b1);
    issue(1'b0, 2'b10, 1'b0, BASE,          32'd0,         32'h8070_F0A5, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd4,  32'd0,         32'hBEEF_5A44, 1'b0);
    idle(1);

    // T5: store followed by load of the same word on the next cycle
    for (int i = 3; i < 8; i++) issue(1'b1, 2'b10, 1'b0, BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), 32'd0, 1'b0);
    issue(1'b1, 2'b10, 1'b0, BASE + 32'd8, 32'h1357_9BDF, 32'd0,         1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0,         32'h1357_9BDF, 1'b0);
    issue(1'b1, 2'b00, 1'b0, BASE + 32'd9, 32'h0000_0077, 32'd0,         1'b0);
    issue(1'b0, 2'b00, 1'b0, BASE + 32'd9, 32'd0,         32'h0000_0077, 1'b0);
    idle(2);
    // T5: eight back-to-back loads
    issue(1'b0, 2'b10, 1'b0, BASE,         32'd0, 32'h8070_F0A5, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd4, 32'd0, 32'hBEEF_5A44, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, 32'h1357_77DF, 1'b0);
    for (int i = 3; i < 8; i++) issue(1'b0, 2'b10, 1'b0, BASE + 32'(4 * i), 32'd0, 32'hA000_0000 + 32'(i), 1'b0);
    idle(6);

    // T6: reset with loads in flight, then again mid-sweep
    issue(1'b0, 2'b10, 1'b0, BASE,         32'd0, 32'h8070_F0A5, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd4, 32'd0, 32'hBEEF_5A44, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd8, 32'd0, 32'h1357_77DF, 1'b0);
    do_reset();
    repeat (5) @(negedge clk);
    do_reset();
    wait_init();
    issue(1'b0, 2'b10, 1'b0, BASE,          32'd0, 32'd0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd4,  32'd0, 32'd0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd8,  32'd0, 32'd0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, BASE + 32'd28, 32'd0, 32'd0, 1'b0);
    req_valid = 1'b0;

    // Drain with a bounded wait
    for (int t = 0; t < 10 && (q0.size() + q1.size() + q2.size() + q3.size()) != 0; t++) @(negedge clk);
    chk("drain_pending", 0, 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
